// File: rtl/lcd_mmio_ctrl_if.sv
// LSU peripheral-bus bundle for lcd_mmio_ctrl: store/load strobes, byte offset, data.
interface lcd_mmio_ctrl_if;
    logic        i_wren;
    logic        i_rden;
    logic [3:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;

    modport master (output i_wren, output i_rden, output i_addr, output i_wdata, input o_rdata);
    modport slave  (input i_wren, input i_rden, input i_addr, input i_wdata, output o_rdata);
endinterface

// File: rtl/lcd_mmio_ctrl.sv
// Memory-mapped HD44780 character LCD controller: bus writes are queued and played out with LCD timing.
// Optional power-on init sequence is built only when LCD_INIT_EN is defined.
module lcd_mmio_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETUP_CYC     = 2,
    parameter int EN_HIGH_CYC   = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int POWERUP_CYC   = 750000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    lcd_mmio_ctrl_if.slave        bus,
    output logic [7:0]            o_lcd_data,
    output logic                  o_lcd_rs,
    output logic                  o_lcd_rw,
    output logic                  o_lcd_en,
    output logic                  o_lcd_on,
    output logic [31:0]           o_io_lcd
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_SETUP = 3'd1, ST_PULSE = 3'd2, ST_HOLD = 3'd3, ST_WAIT = 3'd4, ST_INIT_WAIT = 3'd5
    } state_t;
    localparam state_t RESET_ST = ST_INIT_WAIT;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_SETUP = 3'd1, ST_PULSE = 3'd2, ST_HOLD = 3'd3, ST_WAIT = 3'd4
    } state_t;
    localparam state_t RESET_ST = ST_IDLE;
    localparam int unused_powerup = POWERUP_CYC;
`endif

    state_t             state_r, state_nx;
    logic [31:0]        cnt_r, limit_s;
    logic               done_s;
    logic [8:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic [1:0]         sel_s;
    logic               push_req_s, push_s, pop_s, full_s, empty_s, busy_s, ctrl_wr_s;
    logic               load_s, is_long_s;
    logic [8:0]         load_val_s;
    logic               ovf_r, lcd_on_r, en_r, rs_r;
    logic [7:0]         data_r;
    logic [31:0]        status_s, rdata_s;
    logic               unused_bits_s;

    assign sel_s      = bus.i_addr[3:2];
    assign push_req_s = bus.i_wren && !sel_s[1];
    assign ctrl_wr_s  = bus.i_wren && (sel_s == 2'd3);
    assign full_s     = (count_r == DEPTH_C);
    assign empty_s    = (count_r == '0);
    // Fullness is judged before any same-cycle pop, so a push while full is always dropped.
    assign push_s     = push_req_s && !full_s;
    assign is_long_s  = !rs_r && (data_r == 8'h01 || data_r == 8'h02 || data_r == 8'h03);
    assign done_s     = (cnt_r == limit_s - 32'd1);
    assign unused_bits_s = ^{bus.i_addr[1:0], bus.i_wdata[31:8]};

`ifdef LCD_INIT_EN
    logic [2:0] init_idx_r;
    logic       init_pending_s;
    assign init_pending_s = (init_idx_r != 3'd4);
    assign busy_s = (state_r != ST_IDLE) || !empty_s || init_pending_s;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Init command index advances each time IDLE issues one of the power-on commands.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) init_idx_r <= 3'd0;
        else if (state_r == ST_IDLE && init_pending_s) init_idx_r <= init_idx_r + 3'd1;
    end
`else
    assign busy_s = (state_r != ST_IDLE) || !empty_s;
`endif

    // Per-state dwell length; WAIT length depends on the latched entry.
    always_comb begin
        limit_s = 32'd1;
        case (state_r)
            ST_SETUP: limit_s = 32'(SETUP_CYC);
            ST_PULSE: limit_s = 32'(EN_HIGH_CYC);
            ST_HOLD:  limit_s = 32'(HOLD_CYC);
            ST_WAIT:  limit_s = is_long_s ? 32'(LONG_EXEC_CYC) : 32'(EXEC_CYC);
`ifdef LCD_INIT_EN
            ST_INIT_WAIT: limit_s = 32'(POWERUP_CYC);
`endif
            default:  limit_s = 32'd1;
        endcase
    end

    // Next-state logic and head-of-queue load.
    always_comb begin
        state_nx   = state_r;
        pop_s      = 1'b0;
        load_s     = 1'b0;
        load_val_s = 9'd0;
        case (state_r)
            ST_IDLE: begin
`ifdef LCD_INIT_EN
                if (init_pending_s) begin
                    load_s     = 1'b1;
                    load_val_s = {1'b0, init_cmd(init_idx_r)};
                    state_nx   = ST_SETUP;
                end else if (!empty_s) begin
`else
                if (!empty_s) begin
`endif
                    pop_s      = 1'b1;
                    load_s     = 1'b1;
                    load_val_s = fifo_mem_r[rd_ptr_r];
                    state_nx   = ST_SETUP;
                end else begin
                    state_nx   = ST_IDLE;
                end
            end
            ST_SETUP: if (done_s) state_nx = ST_PULSE; else state_nx = ST_SETUP;
            ST_PULSE: if (done_s) state_nx = ST_HOLD;  else state_nx = ST_PULSE;
            ST_HOLD:  if (done_s) state_nx = ST_WAIT;  else state_nx = ST_HOLD;
            ST_WAIT:  if (done_s) state_nx = ST_IDLE;  else state_nx = ST_WAIT;
`ifdef LCD_INIT_EN
            ST_INIT_WAIT: if (done_s) state_nx = ST_IDLE; else state_nx = ST_INIT_WAIT;
`endif
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State register; the dwell counter restarts on every state change.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= RESET_ST;
            cnt_r   <= 32'd0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= (state_nx != state_r) ? 32'd0 : cnt_r + 32'd1;
        end
    end

    // Command/data FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 9'd0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {~sel_s[0], bus.i_wdata[7:0]};
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow and CTRL power bit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ovf_r    <= 1'b0;
            lcd_on_r <= 1'b0;
        end else begin
            if (push_req_s && full_s) ovf_r <= 1'b1;
            else if (ctrl_wr_s && bus.i_wdata[1]) ovf_r <= 1'b0;
            if (ctrl_wr_s) lcd_on_r <= bus.i_wdata[0];
        end
    end

    // Pin latch: EN tracks the upcoming PULSE state; RS/DATA hold until the next load.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            en_r   <= 1'b0;
            rs_r   <= 1'b0;
            data_r <= 8'd0;
        end else begin
            en_r <= (state_nx == ST_PULSE);
            if (load_s) begin
                rs_r   <= load_val_s[8];
                data_r <= load_val_s[7:0];
            end
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s       = 32'd0;
        status_s[0]    = busy_s;
        status_s[1]    = full_s;
        status_s[2]    = empty_s;
        status_s[3]    = ovf_r;
        status_s[11:8] = 4'(count_r);
    end

    // Combinational read mux; DATA/CMD and idle reads return zero.
    always_comb begin
        rdata_s = 32'd0;
        if (bus.i_rden) begin
            case (sel_s)
                2'd2:    rdata_s = status_s;
                2'd3:    rdata_s = {31'd0, lcd_on_r};
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.o_rdata = rdata_s;
    assign o_lcd_data  = data_r;
    assign o_lcd_rs    = rs_r;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en_r;
    assign o_lcd_on    = lcd_on_r;
    assign o_io_lcd    = {lcd_on_r, 20'd0, en_r, rs_r, 1'b0, data_r};
endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// Self-checking bench for lcd_mmio_ctrl: directed plus randomized bus traffic against a
// queue-and-schedule reference model (each entry occupies 1+SETUP+EN_HIGH+HOLD+exec cycles).
module tb_lcd_mmio_ctrl;
    localparam int DEPTH = 4, S = 1, E = 2, H = 1, X = 4, L = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on;
    logic [31:0] io_lcd;

    lcd_mmio_ctrl_if bus();

    lcd_mmio_ctrl #(
        .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .EN_HIGH_CYC(E), .HOLD_CYC(H),
        .EXEC_CYC(X), .LONG_EXEC_CYC(L), .POWERUP_CYC(5)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .bus(bus),
        .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
        .o_lcd_en(lcd_en), .o_lcd_on(lcd_on), .o_io_lcd(io_lcd)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    // Model: k = index of the last clock edge; entry popped at edge p pulses EN after edges p+S..p+S+E-1
    // and frees the controller at edge p+S+E+H+exec.
    int k = 0, idle_at = -1, pop_edge = -100;
    logic [8:0] q[$];
    logic [8:0] last_m = 9'd0;
    logic ovf_m = 1'b0, on_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic exp_en();
        return (k >= pop_edge + S) && (k < pop_edge + S + E);
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'd0;
        s[0] = (k < idle_at) || (q.size() != 0);
        s[1] = (q.size() == DEPTH);
        s[2] = (q.size() == 0);
        s[3] = ovf_m;
        s[11:8] = 4'(q.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic rd, input logic [3:0] a);
        if (!rd) return 32'd0;
        if (a[3:2] == 2'd2) return exp_status();
        if (a[3:2] == 2'd3) return {31'd0, on_m};
        return 32'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        last_m = 9'd0; ovf_m = 1'b0; on_m = 1'b0;
        idle_at = -1; pop_edge = -100;
    endtask

    task automatic model_edge(input logic wr, input logic [3:0] a, input logic [31:0] wd);
        int  n;
        bit  can_pop;
        logic [8:0] e;
        n = q.size();
        can_pop = (k > idle_at) && (n > 0);
        if (wr && !a[3]) begin
            if (n == DEPTH) ovf_m = 1'b1;
            else q.push_back({~a[2], wd[7:0]});
        end else if (wr && a[3:2] == 2'd3) begin
            on_m = wd[0];
            if (wd[1]) ovf_m = 1'b0;
        end
        if (can_pop) begin
            e = q.pop_front();
            last_m = e;
            pop_edge = k;
            idle_at = k + S + E + H + ((!e[8] && e[7:0] >= 8'd1 && e[7:0] <= 8'd3) ? L : X);
        end
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic [3:0] a, input logic [31:0] wd);
        bus.i_wren = wr; bus.i_rden = rd; bus.i_addr = a; bus.i_wdata = wd;
        #2;
        chk("rdata", bus.o_rdata, exp_rdata(rd, a));
        @(posedge clk);
        k++;
        model_edge(wr, a, wd);
        #1;
        bus.i_wren = 1'b0;
        chk("lcd_en", {31'd0, lcd_en}, {31'd0, exp_en()});
        chk("lcd_rs", {31'd0, lcd_rs}, {31'd0, last_m[8]});
        chk("lcd_data", {24'd0, lcd_data}, {24'd0, last_m[7:0]});
        chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
        chk("lcd_on", {31'd0, lcd_on}, {31'd0, on_m});
        chk("io_lcd", io_lcd, {on_m, 20'd0, exp_en(), last_m[8], 1'b0, last_m[7:0]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'h8, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, dens;
        logic [3:0]  a;
        logic [31:0] wd;
        bus.i_wren = 1'b0; bus.i_rden = 1'b0; bus.i_addr = 4'd0; bus.i_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();

        idle(2);
        cyc(1'b1, 1'b0, 4'h0, 32'h0000_0041);
        idle(12);
        cyc(1'b1, 1'b0, 4'h4, 32'h0000_0001);
        cyc(1'b1, 1'b0, 4'h0, 32'h0000_0042);
        idle(30);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 4'h0, 32'h30 + 32'(i));
        idle(3);
        cyc(1'b1, 1'b0, 4'hC, 32'h0000_0002);
        idle(60);
        cyc(1'b1, 1'b0, 4'hC, 32'h0000_0001);
        cyc(1'b0, 1'b1, 4'hC, 32'd0);
        cyc(1'b0, 1'b1, 4'h0, 32'd0);
        cyc(1'b0, 1'b0, 4'h8, 32'd0);

        for (int ph = 0; ph < 6; ph++) begin
            dens = (ph % 2 == 1) ? 40 : 3;
            for (int c = 0; c < 350; c++) begin
                r  = $urandom_range(0, dens - 1);
                a  = 4'($urandom_range(0, 15));
                wd = $urandom;
                if (r == 0) begin
                    a[3:2] = ($urandom_range(0, 2) == 0) ? 2'd1 : 2'd0;
                    if (a[3:2] == 2'd1 && $urandom_range(0, 1) == 1) wd[7:0] = 8'($urandom_range(0, 4));
                    cyc(1'b1, 1'($urandom_range(0, 1)), a, wd);
                end else if (r == 1 && $urandom_range(0, 3) == 0) begin
                    a[3:2] = 2'd3;
                    cyc(1'b1, 1'($urandom_range(0, 1)), a, wd);
                end else begin
                    cyc(1'b0, 1'($urandom_range(0, 3) != 0), a, wd);
                end
            end
        end

        idle(200);
        cyc(1'b1, 1'b0, 4'h0, 32'h77);
        cyc(1'b1, 1'b0, 4'h0, 32'h78);
        cyc(1'b1, 1'b0, 4'h0, 32'h79);
        for (int i = 0; i < 40 && !exp_en(); i++) idle(1);
        chk("en_before_reset", {31'd0, lcd_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("en_in_reset", {31'd0, lcd_en}, 32'd0);
        chk("io_lcd_in_reset", io_lcd, 32'd0);
        bus.i_rden = 1'b1; bus.i_addr = 4'h8;
        #1;
        chk("status_in_reset", bus.o_rdata, 32'h4);
        model_reset();
        #1 rst_n = 1'b1;
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lcd_mmio_ctrl.md
Name: lcd_mmio_ctrl

Overview:
Memory-mapped HD44780-style character LCD controller. It is the responder on the LSU peripheral bus: the core's store and load accesses land here. CPU stores to the DATA or CMD registers are queued in a FIFO. A timing FSM plays each queued entry out on the LCD pins (RS/RW/DATA plus an EN strobe), then waits the command execution time, so software never busy-waits per byte.

Parameters:
FIFO_DEPTH, 8, command/data FIFO entries (power of 2, ≥2)
SETUP_CYC, 2, cycles RS/DATA stable before EN rises
EN_HIGH_CYC, 12, cycles EN held high
HOLD_CYC, 2, cycles RS/DATA held after EN falls
EXEC_CYC, 2000, post-strobe wait for normal commands/data
LONG_EXEC_CYC, 82000, post-strobe wait for clear (0x01) / home (0x02, 0x03)
POWERUP_CYC, 750000, power-on delay (only with LCD_INIT_EN)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_wren  in  1  bus write strobe (one-cycle, from LSU)
i_rden  in  1  bus read select
i_addr  in  4  byte offset within block; bits[3:2] select register, bits[1:0] ignored
i_wdata  in  32  store data
o_rdata  out  32  load data, combinational
o_lcd_data  out  8  LCD DB[7:0]
o_lcd_rs  out  1  register select (1=data, 0=command)
o_lcd_rw  out  1  read/write, tied 0 (write-only)
o_lcd_en  out  1  enable strobe
o_lcd_on  out  1  LCD power/backlight
o_io_lcd  out  32  packed {o_lcd_on[31], 20'b0, en[10], rs[9], rw[8], data[7:0]}

Behaviour:
- Register map, selected by i_addr[3:2]:
  - 0 DATA (W): push {rs=1, i_wdata[7:0]}.
  - 1 CMD (W): push {rs=0, i_wdata[7:0]}.
  - 2 STATUS (R): bit0 busy (FSM≠IDLE or FIFO non-empty), bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] count; other bits 0.
  - 3 CTRL (R/W): bit0 lcd_on. Writing 1 to bit1 clears overflow; bit1 reads 0.
- o_rdata is combinational. It returns 0 when i_rden=0 or when reading DATA/CMD.
- Push to a full FIFO: entry dropped, overflow←1. Fullness is evaluated before any same-cycle pop, so a push while full is rejected even if the FSM pops that cycle.
- Simultaneous push and pop when not full: both occur, count unchanged.
- FSM states: IDLE→SETUP→PULSE→HOLD→WAIT→IDLE.
  - IDLE: if FIFO non-empty, pop head into the output latch (rs, data) and go to SETUP the next cycle. The latch drives the pins from SETUP onward.
  - SETUP: EN=0, for SETUP_CYC cycles.
  - PULSE: EN=1, for EN_HIGH_CYC cycles.
  - HOLD: EN=0 with rs/data unchanged, for HOLD_CYC cycles.
  - WAIT: counts LONG_EXEC_CYC if rs=0 and data∈{0x01,0x02,0x03}, else EXEC_CYC; then returns to IDLE.
  - Cycle counter reloads on every state entry. Minimum entry period = 1+SETUP+EN_HIGH+HOLD+EXEC cycles.
- o_lcd_data/o_lcd_rs keep their last value in IDLE. o_lcd_rw is always 0.
- o_lcd_on follows CTRL bit0 and does not gate the FSM.
- Reset (asynchronous, any state):
  - FSM→IDLE, FIFO emptied, overflow=0, counters=0.
  - All outputs 0, including an EN pulse in progress, which drops immediately.
  - An aborted transfer is not replayed.

Optional Feature:
LCD_INIT_EN.
- Defined: after reset the FSM enters INIT_WAIT for POWERUP_CYC cycles. It then issues 0x38, 0x0C, 0x06, 0x01 (rs=0) through the normal SETUP/PULSE/HOLD/WAIT path; 0x01 uses LONG_EXEC_CYC. STATUS.busy=1 throughout. CPU pushes are accepted into the FIFO during init and are served only after the 4th init command's WAIT completes.
- Undefined: FSM starts in IDLE after reset, and no INIT_WAIT state or init sequence logic is built.

Test Plan:
(Small parameters: SETUP=1, EN_HIGH=2, HOLD=1, EXEC=4, LONG_EXEC=10, FIFO_DEPTH=4, LCD_INIT_EN undefined.)
1. Write DATA=0x41 → STATUS busy=1 next cycle. Pins rs=1, data=0x41. EN high exactly 2 cycles, starting 2 cycles after the push. STATUS=0x4 (empty, idle) 9 cycles after the push.
2. Write CMD=0x01 → rs=0, data=0x01, one EN pulse. Next queued entry's EN rises only after 10 WAIT cycles.
3. 5 back-to-back DATA writes 0x30..0x34 in IDLE → first popped at once, 4 queued; none overflows (full at count 4). A 6th write while full → STATUS bit3=1, 0x35 never appears on pins. CTRL write 0x2 → bit3=0.
4. Assert i_reset mid-PULSE → o_lcd_en=0 in the same cycle. After release: STATUS=0x4, o_io_lcd=0, remaining FIFO entries discarded.
5. Write CTRL=0x1 → o_lcd_on=1, o_io_lcd[31]=1. Read CTRL=0x1. Read DATA=0. Read with i_rden=0 → 0.
6. With LCD_INIT_EN and POWERUP_CYC=5: reset release → EN pulses carry 0x38, 0x0C, 0x06, 0x01 in order. A DATA 0x48 write during init appears as the 5th pulse.
